fetch_queue: RTL and testbench

Decoupling buffer between instruction fetch and decode. Receives up to two fetched instructions per cycle with their PCs and BTB predictions, stores them in program order in a circular queue, and presents up to two oldest entries per cycle to decode. Back-pressures fetch through `fetch_ready` and is emptied by a pipeline flush on redirect or mispredict.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer decoupling fetch from decode. Accepts up to two
// instructions per cycle in program order and presents the two oldest to decode.
module fetch_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ADDR_WIDTH-1:0]     instruction_addr_0,
    input  logic [ADDR_WIDTH-1:0]     instruction_addr_1,
    input  logic [DATA_WIDTH-1:0]     instruction_0,
    input  logic [DATA_WIDTH-1:0]     instruction_1,
    input  logic [1:0]                instruction_valid,
    input  logic                      predict_taken_0,
    input  logic                      predict_taken_1,
    input  logic [ADDR_WIDTH-1:0]     predict_target_0,
    input  logic [ADDR_WIDTH-1:0]     predict_target_1,
    output logic                      fetch_ready,
    output logic [ADDR_WIDTH-1:0]     dec_addr_0,
    output logic [ADDR_WIDTH-1:0]     dec_addr_1,
    output logic [DATA_WIDTH-1:0]     dec_instr_0,
    output logic [DATA_WIDTH-1:0]     dec_instr_1,
    output logic                      dec_pred_taken_0,
    output logic                      dec_pred_taken_1,
    output logic [ADDR_WIDTH-1:0]     dec_pred_target_0,
    output logic [ADDR_WIDTH-1:0]     dec_pred_target_1,
    output logic [1:0]                dec_valid,
    input  logic                      dec_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instr;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] pred_target;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;

    entry_t            slot_0;
    entry_t            slot_1;
    entry_t            wr_ent_0;
    logic              enq_fire;
    logic              enq_two;
    logic [1:0]        enq_n;
    logic [1:0]        deq_n;
    logic [CNT_W-1:0]  count_next;

    // Pointer neighbours; DEPTH is a power of two so plain increment wraps.
    always_comb begin
        head_p1 = head + PTR_W'(1);
        tail_p1 = tail + PTR_W'(1);
    end

    // Input slot packing and compaction: a lone slot 1 lands at tail.
    always_comb begin
        slot_0.addr        = instruction_addr_0;
        slot_0.instr       = instruction_0;
        slot_0.pred_taken  = predict_taken_0;
        slot_0.pred_target = predict_target_0;
        slot_1.addr        = instruction_addr_1;
        slot_1.instr       = instruction_1;
        slot_1.pred_taken  = predict_taken_1;
        slot_1.pred_target = predict_target_1;
        wr_ent_0           = instruction_valid[0] ? slot_0 : slot_1;
    end

    // Occupancy-derived handshakes; only registered count feeds fetch_ready.
    always_comb begin
        fetch_ready = (count <= CNT_W'(DEPTH - 2));
        dec_valid   = 2'b00;
        if (count >= CNT_W'(2)) begin
            dec_valid = 2'b11;
        end else if (count == CNT_W'(1)) begin
            dec_valid = 2'b01;
        end
    end

    // Enqueue/dequeue amounts and next occupancy; flush drops the enqueue.
    always_comb begin
        enq_fire   = fetch_ready && (instruction_valid != 2'b00) && !flush;
        enq_two    = (instruction_valid == 2'b11);
        enq_n      = 2'd0;
        deq_n      = 2'd0;
        if (enq_fire) begin
            enq_n = {1'b0, instruction_valid[0]} + {1'b0, instruction_valid[1]};
        end
        if (dec_ready) begin
            deq_n = {1'b0, dec_valid[0]} + {1'b0, dec_valid[1]};
        end
        count_next = count + CNT_W'(enq_n) - CNT_W'(deq_n);
    end

    // Head, tail and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count_next;
        end
    end

    // Entry storage; cleared on reset so decode data reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            mem[tail] <= wr_ent_0;
            if (enq_two) begin
                mem[tail_p1] <= slot_1;
            end
        end
    end

    // Decode lanes read the two oldest entries directly from storage.
    always_comb begin
        dec_addr_0        = mem[head].addr;
        dec_instr_0       = mem[head].instr;
        dec_pred_taken_0  = mem[head].pred_taken;
        dec_pred_target_0 = mem[head].pred_target;
        dec_addr_1        = mem[head_p1].addr;
        dec_instr_1       = mem[head_p1].instr;
        dec_pred_taken_1  = mem[head_p1].pred_taken;
        dec_pred_target_1 = mem[head_p1].pred_target;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed plan scenarios plus random traffic,
// checked every cycle against a queue-based model of program-order entries.
module tb_fetch_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [AW-1:0] instruction_addr_0, instruction_addr_1;
    logic [DW-1:0] instruction_0, instruction_1;
    logic [1:0]    instruction_valid;
    logic          predict_taken_0, predict_taken_1;
    logic [AW-1:0] predict_target_0, predict_target_1;
    logic          fetch_ready;
    logic [AW-1:0] dec_addr_0, dec_addr_1;
    logic [DW-1:0] dec_instr_0, dec_instr_1;
    logic          dec_pred_taken_0, dec_pred_taken_1;
    logic [AW-1:0] dec_pred_target_0, dec_pred_target_1;
    logic [1:0]    dec_valid;
    logic          dec_ready;
    logic [3:0]    count;

    fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .instruction_addr_0(instruction_addr_0),
        .instruction_addr_1(instruction_addr_1),
        .instruction_0     (instruction_0),
        .instruction_1     (instruction_1),
        .instruction_valid (instruction_valid),
        .predict_taken_0   (predict_taken_0),
        .predict_taken_1   (predict_taken_1),
        .predict_target_0  (predict_target_0),
        .predict_target_1  (predict_target_1),
        .fetch_ready       (fetch_ready),
        .dec_addr_0        (dec_addr_0),
        .dec_addr_1        (dec_addr_1),
        .dec_instr_0       (dec_instr_0),
        .dec_instr_1       (dec_instr_1),
        .dec_pred_taken_0  (dec_pred_taken_0),
        .dec_pred_taken_1  (dec_pred_taken_1),
        .dec_pred_target_0 (dec_pred_target_0),
        .dec_pred_target_1 (dec_pred_target_1),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic          pt;
        logic [AW-1:0] tgt;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a program-order list of entries.
    int m_sz;
    int m_n;
    bit m_fr;
    ent_t m_e;
    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            mq.delete();
        end else begin
            m_sz = mq.size();
            m_fr = (DEPTH - m_sz) >= 2;
            if (dec_ready) begin
                m_n = (m_sz >= 2) ? 2 : m_sz;
                repeat (m_n) void'(mq.pop_front());
            end
            if (m_fr) begin
                if (instruction_valid[0]) begin
                    m_e.addr = instruction_addr_0; m_e.instr = instruction_0;
                    m_e.pt = predict_taken_0;      m_e.tgt = predict_target_0;
                    mq.push_back(m_e);
                end
                if (instruction_valid[1]) begin
                    m_e.addr = instruction_addr_1; m_e.instr = instruction_1;
                    m_e.pt = predict_taken_1;      m_e.tgt = predict_target_1;
                    mq.push_back(m_e);
                end
            end
        end
    end

    // Compare process: DUT outputs against the model each cycle.
    always @(negedge clk) begin
        int sz;
        logic [1:0] ev;
        sz = mq.size();
        ev = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
        chk("count", 64'(count), 64'(sz));
        chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - sz) >= 2));
        chk("dec_valid", 64'(dec_valid), 64'(ev));
        if (sz >= 1) begin
            chk("lane0_addr", 64'(dec_addr_0), 64'(mq[0].addr));
            chk("lane0_instr", 64'(dec_instr_0), 64'(mq[0].instr));
            chk("lane0_pt", 64'(dec_pred_taken_0), 64'(mq[0].pt));
            chk("lane0_tgt", 64'(dec_pred_target_0), 64'(mq[0].tgt));
        end
        if (sz >= 2) begin
            chk("lane1_addr", 64'(dec_addr_1), 64'(mq[1].addr));
            chk("lane1_instr", 64'(dec_instr_1), 64'(mq[1].instr));
            chk("lane1_pt", 64'(dec_pred_taken_1), 64'(mq[1].pt));
            chk("lane1_tgt", 64'(dec_pred_target_1), 64'(mq[1].tgt));
        end
    end

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] pc0, input logic [AW-1:0] pc1,
                         input logic dr, input logic fl);
        instruction_valid  = v;
        instruction_addr_0 = pc0;
        instruction_addr_1 = pc1;
        instruction_0      = ~pc0 ^ 32'h1357_0000;
        instruction_1      = ~pc1 ^ 32'h2468_0000;
        predict_taken_0    = pc0[3];
        predict_taken_1    = pc1[3];
        predict_target_0   = pc0 + 32'h1000;
        predict_target_1   = pc1 + 32'h2000;
        dec_ready          = dr;
        flush              = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_ready"}, 64'(fetch_ready), 64'd1);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_data"}, 64'({dec_addr_0, dec_addr_1}), 64'd0);
        chk({tag, "_instr"}, 64'({dec_instr_0, dec_instr_1}), 64'd0);
        chk({tag, "_pred"}, 64'({dec_pred_taken_0, dec_pred_taken_1}), 64'd0);
        chk({tag, "_tgt"}, 64'({dec_pred_target_0, dec_pred_target_1}), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] pc;
        logic [AW-1:0] exp_pc;
        int sz;
        rst = 1'b0;
        drive(2'b00, '0, '0, 1'b0, 1'b0);

        // Reset held three cycles.
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        // Fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'(i * 8), 32'(i * 8 + 4), 1'b0, 1'b0);
            tick();
            chk("fill_count", 64'(count), 64'(2 * (i + 1)));
        end
        chk("full_fetch_ready", 64'(fetch_ready), 64'd0);
        drive(2'b11, 32'h20, 32'h24, 1'b0, 1'b0);
        tick();
        chk("full_ignored_count", 64'(count), 64'd8);

        // Drain while refilling, across the pointer wrap.
        pc = 32'h20;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, pc, pc + 32'h4, 1'b1, 1'b0);
            chk("drain_addr0", 64'(dec_addr_0), 64'(exp_pc));
            chk("drain_addr1", 64'(dec_addr_1), 64'(exp_pc + 32'h4));
            if ((DEPTH - mq.size()) >= 2) pc = pc + 32'h8;
            exp_pc = exp_pc + 32'h8;
            tick();
        end
        drive(2'b00, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && count != 4'd0; i++) tick();
        chk("drained", 64'(count), 64'd0);

        // Odd count and compaction.
        drive(2'b01, 32'h100, 32'h104, 1'b0, 1'b0);
        tick();
        drive(2'b10, 32'h104, 32'h108, 1'b0, 1'b0);
        tick();
        chk("cmp_count", 64'(count), 64'd2);
        chk("cmp_addr0", 64'(dec_addr_0), 64'h100);
        chk("cmp_addr1", 64'(dec_addr_1), 64'h108);
        chk("cmp_valid", 64'(dec_valid), 64'd3);
        drive(2'b00, '0, '0, 1'b1, 1'b0);
        tick();
        drive(2'b01, 32'h200, 32'h204, 1'b0, 1'b0);
        tick();
        chk("one_valid", 64'(dec_valid), 64'd1);
        chk("one_addr0", 64'(dec_addr_0), 64'h200);
        drive(2'b00, '0, '0, 1'b1, 1'b0);
        tick();
        chk("one_deq_count", 64'(count), 64'd0);

        // Flush beats enqueue and dequeue.
        drive(2'b11, 32'h300, 32'h304, 1'b0, 1'b0); tick();
        drive(2'b11, 32'h308, 32'h30C, 1'b0, 1'b0); tick();
        drive(2'b01, 32'h310, 32'h314, 1'b0, 1'b0); tick();
        chk("pre_flush_count", 64'(count), 64'd5);
        drive(2'b11, 32'h318, 32'h31C, 1'b1, 1'b1); tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(dec_valid), 64'd0);
        chk("flush_ready", 64'(fetch_ready), 64'd1);

        // Prediction passthrough, then asynchronous reset mid-cycle.
        drive(2'b01, 32'h500, 32'h504, 1'b0, 1'b0);
        predict_taken_0  = 1'b1;
        predict_target_0 = 32'h400;
        tick();
        chk("pred_taken0", 64'(dec_pred_taken_0), 64'd1);
        chk("pred_target0", 64'(dec_pred_target_0), 64'h400);
        drive(2'b11, 32'h600, 32'h604, 1'b0, 1'b0);
        tick();
        #1 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        drive(2'b00, '0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom,
                  (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 63) == 0);
            instruction_0    = $urandom;
            instruction_1    = $urandom;
            predict_taken_0  = 1'($urandom);
            predict_taken_1  = 1'($urandom);
            predict_target_0 = $urandom;
            predict_target_1 = $urandom;
            tick();
        end
        drive(2'b00, '0, '0, 1'b0, 1'b0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
